// File: rtl/point_scalar_mult.sv
// point_scalar_mult: left-to-right double-and-add sequencer driving external point double/add units
package point_scalar_mult_pkg;
  typedef struct packed {
    logic [255:0] x;
    logic [255:0] y;
  } curve_point_t;
endpackage

module point_scalar_mult
  import point_scalar_mult_pkg::*;
#(
  parameter int KEY_WIDTH = 256
) (
  input  logic                 clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [KEY_WIDTH-1:0] k,
  input  curve_point_t         P,
  output logic                 Done,
  output curve_point_t         R,
  output logic                 R_inf,
  output logic                 busy,
  output logic                 dbl_Reset,
  output curve_point_t         dbl_P,
  input  logic                 dbl_Done,
  input  curve_point_t         dbl_R,
  output logic                 add_Reset,
  output curve_point_t         add_P,
  output curve_point_t         add_Q,
  input  logic                 add_Done,
  input  curve_point_t         add_R
);
  localparam int IW = $clog2(KEY_WIDTH);
  typedef enum logic [2:0] {IDLE, SCAN, DBL, ADD, NEXT, DONE} state_t;
  state_t state, next;
  logic [KEY_WIDTH-1:0] k_reg;
  curve_point_t p_reg, acc;
  logic [IW-1:0] idx;
  logic dbl_live, add_live, dbl_ok, add_ok, last;
  // A unit's Done only counts once its Reset has been low for a full cycle
  assign dbl_ok = state == DBL && dbl_live && dbl_Done;
  assign add_ok = state == ADD && add_live && add_Done;
  assign last = idx == '0;
  assign Done = state == DONE;
  assign busy = state inside {SCAN, DBL, ADD, NEXT};
  assign dbl_Reset = state != DBL;
  assign add_Reset = state != ADD;
  assign dbl_P = acc;
  assign add_P = acc;
  assign add_Q = p_reg;
  always_ff @(posedge clk)
    state <= Reset ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE: next = start ? SCAN : state;
      SCAN: next = last ? DONE : (k_reg[idx] ? DBL : SCAN);
      DBL: next = dbl_ok ? (k_reg[idx] ? ADD : NEXT) : DBL;
      ADD: next = add_ok ? NEXT : ADD;
      NEXT: next = last ? DONE : DBL;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (Reset) begin
      k_reg <= '0;
      p_reg <= '0;
      acc <= '0;
      idx <= IW'(KEY_WIDTH - 1);
      R <= '0;
      R_inf <= 1'b0;
      dbl_live <= 1'b0;
      add_live <= 1'b0;
    end else begin
      dbl_live <= state == DBL;
      add_live <= state == ADD;
      case (state)
        IDLE, DONE: if (start) begin
          k_reg <= k;
          p_reg <= P;
          idx <= IW'(KEY_WIDTH - 1);
        end
        SCAN: begin
          if (k_reg[idx]) acc <= p_reg;
          if (!last) idx <= idx - 1'b1;
          else begin
            R <= k_reg[idx] ? p_reg : '0;
            R_inf <= !k_reg[idx];
          end
        end
        DBL: if (dbl_ok) acc <= dbl_R;
        ADD: if (add_ok) acc <= add_R;
        NEXT: begin
          if (!last) idx <= idx - 1'b1;
          else begin
            R <= acc;
            R_inf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_point_scalar_mult.sv
// tb_point_scalar_mult: randomized double-and-add sequencing checked against k*P and a cycle-latency model
module tb_point_scalar_mult;
  import point_scalar_mult_pkg::*;
  localparam int KW = 8;
  logic clk = 0, Reset = 1, start = 0;
  logic [KW-1:0] k = '0;
  curve_point_t P = '0;
  logic Done, R_inf, busy, dbl_Reset, add_Reset, dbl_Done, add_Done;
  curve_point_t R, dbl_P, dbl_R, add_P, add_Q, add_R;
  int n_checks = 0, n_fail = 0, cyc = 0;
  int td = 3, ta = 2;
  bit early = 0;
  int dcnt = 0, acnt = 0;
  int dbl_visits = 0, add_visits = 0, unstable = 0;
  logic dr_prev = 1, ar_prev = 1;
  curve_point_t dp_prev, ap_prev, aq_prev;

  always #5 clk = ~clk;

  point_scalar_mult #(.KEY_WIDTH(KW)) dut (
    .clk(clk), .Reset(Reset), .start(start), .k(k), .P(P),
    .Done(Done), .R(R), .R_inf(R_inf), .busy(busy),
    .dbl_Reset(dbl_Reset), .dbl_P(dbl_P), .dbl_Done(dbl_Done), .dbl_R(dbl_R),
    .add_Reset(add_Reset), .add_P(add_P), .add_Q(add_Q), .add_Done(add_Done), .add_R(add_R)
  );

  // Behavioural arithmetic stubs: doubling and addition on plain integers
  always @(posedge clk) begin
    dcnt <= dbl_Reset ? 0 : dcnt + 1;
    acnt <= add_Reset ? 0 : acnt + 1;
  end
  always_comb begin
    dbl_Done = !dbl_Reset && (dcnt == td - 1 || (early && dcnt == 0));
    dbl_R.x = (early && dcnt == 0) ? 256'hBAD : dbl_P.x << 1;
    dbl_R.y = dbl_P.y << 1;
    add_Done = !add_Reset && acnt == ta - 1;
    add_R.x = add_P.x + add_Q.x;
    add_R.y = add_P.y + add_Q.y;
  end

  always @(negedge clk) begin
    if (!dbl_Reset && dr_prev) dbl_visits++;
    if (!dbl_Reset && !dr_prev && dbl_P !== dp_prev) unstable++;
    if (!add_Reset && ar_prev) add_visits++;
    if (!add_Reset && !ar_prev && {add_P, add_Q} !== {ap_prev, aq_prev}) unstable++;
    dr_prev = dbl_Reset;
    ar_prev = add_Reset;
    dp_prev = dbl_P;
    ap_prev = add_P;
    aq_prev = add_Q;
  end

  function automatic int msb_pos(input logic [KW-1:0] kk);
    int m = -1;
    for (int i = 0; i < KW; i++) if (kk[i]) m = i;
    return m;
  endfunction

  function automatic int exp_lat(input logic [KW-1:0] kk, input int d, input int a);
    int m = msb_pos(kk);
    if (m < 0) return 1 + KW;
    return 1 + (KW - m) + m * (d + 1) + ($countones(kk) - 1) * a;
  endfunction

  task automatic kick(input logic [KW-1:0] kk, input logic [255:0] px, input logic [255:0] py);
    @(negedge clk);
    k = kk;
    P.x = px;
    P.y = py;
    start = 1;
    dbl_visits = 0;
    add_visits = 0;
    @(negedge clk);
    start = 0;
    cyc = 1;
  endtask

  task automatic wait_done();
    while (!Done && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", Done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (R !== '0) begin n_fail++; $display("FAIL reset_R got %h want 0", R.x); end
    n_checks++; if (R_inf !== 1'b0) begin n_fail++; $display("FAIL reset_R_inf got %b want 0", R_inf); end
    n_checks++; if ({dbl_Reset, add_Reset} !== 2'b11) begin n_fail++; $display("FAIL reset_unit_resets got %b want 11", {dbl_Reset, add_Reset}); end
    n_checks++; if ({dbl_P, add_Q} !== '0) begin n_fail++; $display("FAIL reset_operands got %h/%h want 0", dbl_P.x, add_Q.x); end
    Reset = 0;
    @(negedge clk);
    n_checks++; if ({Done, busy} !== 2'b00) begin n_fail++; $display("FAIL idle_after_reset got %b want 00", {Done, busy}); end
  endtask

  task automatic test_scalar_mult(input int n_rand);
    logic [KW-1:0] tbl[5] = '{8'h0B, 8'h00, 8'h01, 8'hFF, 8'h80};
    for (int i = 0; i < 5 + n_rand; i++) begin
      logic [KW-1:0] kk;
      logic [255:0] px, py, ex, ey;
      int m;
      kk = (i < 5) ? tbl[i] : KW'($urandom);
      px = (i == 0 || i == 3) ? 256'd1 : (i == 2 ? 256'd5 : 256'({$urandom, $urandom}));
      py = 256'($urandom);
      ex = 256'(kk) * px;
      ey = 256'(kk) * py;
      m = msb_pos(kk);
      kick(kk, px, py);
      wait_done();
      n_checks++; if (cyc !== exp_lat(kk, td, ta)) begin n_fail++; $display("FAIL latency k=%h got %0d want %0d", kk, cyc, exp_lat(kk, td, ta)); end
      n_checks++; if (R.x !== ex || R.y !== ey) begin n_fail++; $display("FAIL result k=%h got %h,%h want %h,%h", kk, R.x, R.y, ex, ey); end
      n_checks++; if (R_inf !== (kk == 0)) begin n_fail++; $display("FAIL r_inf k=%h got %b want %b", kk, R_inf, kk == 0); end
      n_checks++; if (dbl_visits !== (m < 0 ? 0 : m)) begin n_fail++; $display("FAIL dbl_visits k=%h got %0d want %0d", kk, dbl_visits, m < 0 ? 0 : m); end
      n_checks++; if (add_visits !== (m < 0 ? 0 : $countones(kk) - 1)) begin n_fail++; $display("FAIL add_visits k=%h got %0d want %0d", kk, add_visits, m < 0 ? 0 : $countones(kk) - 1); end
    end
  endtask

  task automatic test_early_done();
    early = 1;
    td = 2;
    kick(8'h0B, 256'd1, 256'd3);
    wait_done();
    n_checks++; if (R.x !== 256'd11 || R.y !== 256'd33) begin n_fail++; $display("FAIL early_done_result got %h,%h want b,21", R.x, R.y); end
    n_checks++; if (cyc !== exp_lat(8'h0B, 2, 2)) begin n_fail++; $display("FAIL early_done_latency got %0d want %0d", cyc, exp_lat(8'h0B, 2, 2)); end
    early = 0;
    td = 3;
  endtask

  task automatic test_reset_mid_op();
    int t = 0;
    kick(8'h0B, 256'd1, 256'd1);
    while (dbl_visits < 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_checks++; if (dbl_visits !== 2) begin n_fail++; $display("FAIL reach_2nd_dbl got %0d want 2", dbl_visits); end
    Reset = 1;
    @(negedge clk);
    n_checks++; if ({Done, busy, dbl_Reset, add_Reset} !== 4'b0011) begin n_fail++; $display("FAIL mid_reset_state got %b want 0011", {Done, busy, dbl_Reset, add_Reset}); end
    n_checks++; if (R !== '0 || dbl_P !== '0) begin n_fail++; $display("FAIL mid_reset_clear got %h/%h want 0", R.x, dbl_P.x); end
    Reset = 0;
    kick(8'h0B, 256'd1, 256'd1);
    wait_done();
    n_checks++; if (R.x !== 256'd11 || cyc !== 22) begin n_fail++; $display("FAIL restart got %h in %0d want b in 22", R.x, cyc); end
  endtask

  task automatic test_busy_ignore();
    curve_point_t held;
    kick(8'h0B, 256'd1, 256'd2);
    repeat (3) begin
      @(negedge clk); cyc++;
      k = KW'($urandom);
      P.x = 256'd77;
      start = 1;
      @(negedge clk); cyc++;
      start = 0;
    end
    wait_done();
    n_checks++; if (R.x !== 256'd11 || R.y !== 256'd22) begin n_fail++; $display("FAIL busy_ignore_result got %h,%h want b,16", R.x, R.y); end
    n_checks++; if (cyc !== 22) begin n_fail++; $display("FAIL busy_ignore_latency got %0d want 22", cyc); end
    held = R;
    k = 8'hFF;
    P.x = 256'd9;
    repeat (5) @(negedge clk);
    n_checks++; if (Done !== 1'b1 || R !== held) begin n_fail++; $display("FAIL done_hold got %b/%h want 1/%h", Done, R.x, held.x); end
    kick(8'h03, 256'd2, 256'd5);
    n_checks++; if ({Done, busy} !== 2'b01) begin n_fail++; $display("FAIL restart_from_done got %b want 01", {Done, busy}); end
    wait_done();
    n_checks++; if (R.x !== 256'd6 || R.y !== 256'd15) begin n_fail++; $display("FAIL second_run got %h,%h want 6,f", R.x, R.y); end
    n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL operand_stability got %0d changes want 0", unstable); end
  endtask

  initial begin
    test_reset();
    test_scalar_mult(12);
    test_early_done();
    test_reset_mid_op();
    test_busy_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
